// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants and helpers for the forwarding / hazard unit.
// Default geometry matches the classic 5-stage pipeline with a 32-entry regfile.
package fwd_hazard_unit_pkg;

   localparam int unsigned DEF_NUM_STG = 3;
   localparam int unsigned DEF_RA_W    = 5;

   // Operand mux select value meaning "take the register file read".
   localparam int unsigned FWD_RF = 0;

   function automatic int unsigned sel_w(input int unsigned num_stg);
      return $clog2(num_stg + 1);
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_sel.sv
// Per-operand priority encoder: picks the youngest forwarding stage whose
// destination matches the source register (register 0 never forwards).
module fwd_sel_prio
   import fwd_hazard_unit_pkg::*;
#(
   parameter int unsigned NUM_STG = DEF_NUM_STG,
   parameter int unsigned RA_W    = DEF_RA_W,
   parameter int unsigned SEL_W   = sel_w(NUM_STG)
) (
   input  logic [RA_W-1:0]         src_i,
   input  logic [NUM_STG-1:0]      stg_we_i,
   input  logic [NUM_STG*RA_W-1:0] stg_rd_i,
   output logic [SEL_W-1:0]        sel_o
);

   // Scan oldest to youngest so the youngest match is the last assignment.
   always_comb begin
      sel_o = SEL_W'(FWD_RF);
      if (src_i != '0) begin
         for (int unsigned k = NUM_STG; k > 0; k--) begin
            if (stg_we_i[k-1] && (stg_rd_i[(k-1)*RA_W +: RA_W] == src_i)) begin
               sel_o = SEL_W'(k);
            end
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding plus ID interlock (load-use, long-latency RAW/WAW,
// outstanding-op limit) with a busy scoreboard and saturating stall counter.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned NUM_STG = DEF_NUM_STG,
   parameter int unsigned RA_W    = DEF_RA_W,
   parameter int unsigned MAX_OUT = 4,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned SEL_W   = sel_w(NUM_STG)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           id_valid,
   input  logic [NUM_SRC*RA_W-1:0]        id_src,
   input  logic [NUM_SRC-1:0]             id_src_used,
   input  logic [RA_W-1:0]                id_rd,
   input  logic                           id_we,
   input  logic                           id_long,
   input  logic [NUM_SRC*RA_W-1:0]        ex_src,
   input  logic [NUM_STG-1:0]             stg_we,
   input  logic [NUM_STG*RA_W-1:0]        stg_rd,
   input  logic [NUM_STG-1:0]             stg_rdy,
   input  logic                           lu_done,
   input  logic [RA_W-1:0]                lu_rd,
   input  logic                           flush,
   output logic [NUM_SRC*SEL_W-1:0]       fwd_sel,
   output logic                           id_stall,
   output logic [2**RA_W-1:0]             busy_vec,
   output logic [$clog2(MAX_OUT+1)-1:0]   out_cnt,
   output logic [CNT_W-1:0]               stall_cnt
);

   localparam int unsigned OC_W = $clog2(MAX_OUT + 1);

   logic [2**RA_W-1:0] busy_q, busy_d;
   logic [OC_W-1:0]    out_cnt_q, out_cnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic               hazard, issue, long_issue, lu_ret;
   logic [RA_W-1:0]    src;
   logic               unused_rdy;

   // Only stage 1 can still be waiting on a load; older stages are complete.
   assign unused_rdy = &{1'b0, stg_rdy};

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_fwd
      fwd_sel_prio #(
         .NUM_STG (NUM_STG),
         .RA_W    (RA_W),
         .SEL_W   (SEL_W)
      ) u_prio (
         .src_i    (ex_src[s*RA_W +: RA_W]),
         .stg_we_i (stg_we),
         .stg_rd_i (stg_rd),
         .sel_o    (fwd_sel[s*SEL_W +: SEL_W])
      );
   end

   always_comb begin
      hazard = 1'b0;
      src    = '0;
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
         src = id_src[s*RA_W +: RA_W];
         if (id_src_used[s] && (src != '0)) begin
            if (stg_we[0] && (stg_rd[RA_W-1:0] == src) && !stg_rdy[0]) begin
               hazard = 1'b1;
            end
            // A write-back landing this cycle reaches ID through regfile write-through.
            if (busy_q[src] && !(lu_done && (lu_rd == src))) begin
               hazard = 1'b1;
            end
         end
      end
      if (id_we && (id_rd != '0) && busy_q[id_rd]) begin
         hazard = 1'b1;
      end
      if (id_long && (out_cnt_q == OC_W'(MAX_OUT)) && !lu_done) begin
         hazard = 1'b1;
      end
   end

   assign id_stall   = id_valid & ~flush & hazard;
   assign issue      = id_valid & ~id_stall & ~flush;
   assign long_issue = issue & id_long;
   assign lu_ret     = lu_done & (out_cnt_q != '0);

   // Clear before set so a same-cycle set on the completing register wins.
   always_comb begin
      busy_d = busy_q;
      if (lu_ret) begin
         busy_d[lu_rd] = 1'b0;
      end
      if (long_issue && id_we && (id_rd != '0)) begin
         busy_d[id_rd] = 1'b1;
      end
   end

   always_comb begin
      out_cnt_d = out_cnt_q;
      if (long_issue && !lu_ret) begin
         out_cnt_d = out_cnt_q + OC_W'(1);
      end else if (!long_issue && lu_ret) begin
         out_cnt_d = out_cnt_q - OC_W'(1);
      end
      stall_cnt_d = stall_cnt_q;
      if (id_stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= '0;
         out_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         busy_q      <= busy_d;
         out_cnt_q   <= out_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign busy_vec  = busy_q;
   assign out_cnt   = out_cnt_q;
   assign stall_cnt = stall_cnt_q;

   a_lu_done_ok : assert property (@(posedge clk) disable iff (!rst_n)
                                   !(lu_done && (out_cnt_q == '0)));

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_fwd_hazard_unit;

   localparam int NS = 2, NG = 3, RW = 5, MO = 4, CW = 4, SW = 2;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           id_valid, id_we, id_long, lu_done, flush;
   logic [NS*RW-1:0] id_src, ex_src;
   logic [NS-1:0]  id_src_used;
   logic [RW-1:0]  id_rd, lu_rd;
   logic [NG-1:0]  stg_we, stg_rdy;
   logic [NG*RW-1:0] stg_rd;
   logic [NS*SW-1:0] fwd_sel;
   logic           id_stall;
   logic [31:0]    busy_vec;
   logic [2:0]     out_cnt;
   logic [CW-1:0]  stall_cnt;

   int n_chk = 0, n_err = 0;

   // Model state: set of busy registers, outstanding count, stall count.
   bit [31:0] m_busy;
   int        m_oc, m_sc;

   fwd_hazard_unit #(.NUM_SRC(NS), .NUM_STG(NG), .RA_W(RW), .MAX_OUT(MO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
      .id_src_used(id_src_used), .id_rd(id_rd), .id_we(id_we), .id_long(id_long),
      .ex_src(ex_src), .stg_we(stg_we), .stg_rd(stg_rd), .stg_rdy(stg_rdy),
      .lu_done(lu_done), .lu_rd(lu_rd), .flush(flush), .fwd_sel(fwd_sel),
      .id_stall(id_stall), .busy_vec(busy_vec), .out_cnt(out_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int stage_rd(input int k);
      logic [NG*RW-1:0] v;
      v = stg_rd;
      return int'(v[(k-1)*RW +: RW]);
   endfunction

   function automatic int exp_sel(input int s);
      logic [NS*RW-1:0] v;
      int r;
      v = ex_src;
      r = int'(v[s*RW +: RW]);
      if (r == 0) return 0;
      for (int k = 1; k <= NG; k++)
         if (stg_we[k-1] && stage_rd(k) == r) return k;
      return 0;
   endfunction

   function automatic bit exp_stall();
      logic [NS*RW-1:0] v;
      bit haz;
      int r;
      v = id_src;
      haz = 0;
      for (int s = 0; s < NS; s++) begin
         r = int'(v[s*RW +: RW]);
         if (id_src_used[s] && r != 0) begin
            if (stg_we[0] && stage_rd(1) == r && !stg_rdy[0]) haz = 1;
            if (m_busy[r] && !(lu_done && int'(lu_rd) == r)) haz = 1;
         end
      end
      if (id_we && id_rd != 0 && m_busy[id_rd]) haz = 1;
      if (id_long && m_oc == MO && !lu_done) haz = 1;
      return id_valid && !flush && haz;
   endfunction

   task automatic model_reset();
      m_busy = '0; m_oc = 0; m_sc = 0;
   endtask

   task automatic model_update();
      bit st, iss;
      st  = exp_stall();
      iss = id_valid && !st && !flush;
      if (st && m_sc < CNT_MAX) m_sc++;
      if (lu_done && m_oc > 0) begin
         m_busy[lu_rd] = 1'b0;
         m_oc--;
      end
      if (iss && id_long) begin
         m_oc++;
         if (id_we && id_rd != 0) m_busy[id_rd] = 1'b1;
      end
   endtask

   task automatic compare_model();
      logic [NS*SW-1:0] fs;
      fs = fwd_sel;
      for (int s = 0; s < NS; s++)
         chk($sformatf("fwd_sel%0d", s), 32'(fs[s*SW +: SW]), 32'(exp_sel(s)));
      chk("id_stall", 32'(id_stall), 32'(exp_stall()));
      chk("busy_vec", busy_vec, m_busy);
      chk("out_cnt", 32'(out_cnt), 32'(m_oc));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_sc));
   endtask

   // Inputs set at posedge+1; model compared before next edge, advanced after it.
   task automatic cycle();
      #1 compare_model();
      @(posedge clk);
      #1 model_update();
   endtask

   task automatic idle();
      id_valid = 0; id_src = '0; id_src_used = '0; id_rd = '0; id_we = 0; id_long = 0;
      ex_src = '0; stg_we = '0; stg_rd = '0; stg_rdy = '1; lu_done = 0; lu_rd = '0; flush = 0;
   endtask

   function automatic logic [RW-1:0] rr();
      return RW'($urandom_range(0, 7));
   endfunction

   initial begin
      idle();
      model_reset();
      rst_n = 0;
      #2;
      chk("rst_busy", busy_vec, 32'h0);
      chk("rst_out_cnt", 32'(out_cnt), 32'h0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
      chk("rst_id_stall", 32'(id_stall), 32'h0);
      chk("rst_fwd_sel", 32'(fwd_sel), 32'h0);
      @(posedge clk); @(posedge clk);
      #1 rst_n = 1;

      // Forwarding priority and register 0
      idle(); stg_we = 3'b011; stg_rd = {5'd0, 5'd5, 5'd5}; ex_src = {5'd0, 5'd5};
      #1 chk("fwd_young_wins", 32'(fwd_sel[1:0]), 32'd1);
      cycle();
      idle(); stg_we = 3'b001; stg_rd = '0; ex_src = '0;
      #1 chk("fwd_r0", 32'(fwd_sel[1:0]), 32'd0);
      cycle();

      // Load-use
      idle(); id_valid = 1; stg_we = 3'b001; stg_rd = {10'd0, 5'd8}; stg_rdy = 3'b110;
      id_src = {5'd0, 5'd8}; id_src_used = 2'b01;
      #1 chk("load_use_stall", 32'(id_stall), 32'd1);
      cycle();
      chk("load_use_cnt", 32'(stall_cnt), 32'd1);
      id_src_used = 2'b00;
      #1 chk("load_use_unused", 32'(id_stall), 32'd0);
      cycle();

      // Long issue, dependent reader released on completion cycle
      idle(); id_valid = 1; id_long = 1; id_we = 1; id_rd = 5'd10;
      #1 chk("long_issue_nostall", 32'(id_stall), 32'd0);
      cycle();
      chk("busy10_set", 32'(busy_vec[10]), 32'd1);
      chk("out_cnt_1", 32'(out_cnt), 32'd1);
      idle(); id_valid = 1; id_src = {5'd0, 5'd10}; id_src_used = 2'b01;
      #1 chk("raw_busy_stall", 32'(id_stall), 32'd1);
      cycle(); cycle();
      lu_done = 1; lu_rd = 5'd10;
      #1 chk("raw_bypass", 32'(id_stall), 32'd0);
      cycle();
      chk("busy10_clr", 32'(busy_vec[10]), 32'd0);

      // Outstanding limit
      for (int i = 1; i <= 4; i++) begin
         idle(); id_valid = 1; id_long = 1; id_we = 1; id_rd = RW'(i);
         cycle();
      end
      chk("out_cnt_full", 32'(out_cnt), 32'd4);
      id_rd = 5'd5;
      #1 chk("struct_stall", 32'(id_stall), 32'd1);
      cycle();
      lu_done = 1; lu_rd = 5'd1;
      #1 chk("struct_release", 32'(id_stall), 32'd0);
      cycle();
      chk("out_cnt_hold", 32'(out_cnt), 32'd4);
      chk("busy5_set", 32'(busy_vec[5]), 32'd1);

      // Set beats clear on the same register, then WAW
      idle(); id_valid = 1; id_long = 1; id_we = 1; id_rd = 5'd12; lu_done = 1; lu_rd = 5'd12;
      cycle();
      chk("busy12_setwins", 32'(busy_vec[12]), 32'd1);
      idle(); id_valid = 1; id_we = 1; id_rd = 5'd12;
      #1 chk("waw_stall", 32'(id_stall), 32'd1);
      cycle();

      // Flush suppresses stall and issue
      idle(); id_valid = 1; flush = 1; id_src = {5'd0, 5'd12}; id_src_used = 2'b01;
      id_long = 1; id_we = 1; id_rd = 5'd20;
      #1 chk("flush_nostall", 32'(id_stall), 32'd0);
      cycle();
      chk("flush_nobusy", 32'(busy_vec[20]), 32'd0);

      // Asynchronous reset mid-cycle
      idle();
      #1 rst_n = 0;
      #1;
      chk("async_busy", busy_vec, 32'h0);
      chk("async_out_cnt", 32'(out_cnt), 32'h0);
      chk("async_stall_cnt", 32'(stall_cnt), 32'h0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1;

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 499) begin
            rst_n = 0;
            model_reset();
            @(posedge clk);
            #1 rst_n = 1;
         end
         id_valid = ($urandom % 4) != 0;
         id_src = {rr(), rr()};
         id_src_used = 2'($urandom);
         id_rd = rr();
         id_we = 1'($urandom);
         id_long = ($urandom % 3) == 0;
         ex_src = {rr(), rr()};
         stg_we = 3'($urandom);
         stg_rd = {rr(), rr(), rr()};
         stg_rdy = 3'($urandom);
         lu_done = (m_oc > 0) && (($urandom % 3) == 0);
         lu_rd = rr();
         flush = ($urandom % 8) == 0;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
